tlb_lru_tracker: RTL and testbench

TLB_LRU_TRACKER -- requirements
Module: tlb_lru_tracker

---
 rtl/tlb_lru_tracker_pkg.sv | 13 +
 rtl/tlb_lru_pick.sv | 47 ++++
 rtl/tlb_lru_tracker.sv | 128 ++++++++++++
 tb/tb_tlb_lru_tracker.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_lru_tracker_pkg.sv
// Shared defaults and FSM state encoding for the TLB LRU tracker.
package tlb_lru_tracker_pkg;

  localparam int unsigned NUM_WAYS_DEF = 4;
  localparam int unsigned LRU_BITS_DEF = 4;
  localparam int unsigned NUM_SETS_DEF = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } tracker_state_t;

endpackage

// File: rtl/tlb_lru_pick.sv
// Combinational selection over one set: first invalid way, else the
// least-recently-used way (ties to lowest index), plus the largest counter.
module tlb_lru_pick
  import tlb_lru_tracker_pkg::*;
#(
  parameter int unsigned NUM_WAYS = NUM_WAYS_DEF,
  parameter int unsigned LRU_BITS = LRU_BITS_DEF,
  localparam int unsigned WAY_BITS = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS*LRU_BITS-1:0] counts,
  input  logic [NUM_WAYS-1:0]          valid_mask,
  output logic [WAY_BITS-1:0]          victim_way,
  output logic [LRU_BITS-1:0]          max_count
);

  logic                found_inv;
  logic [WAY_BITS-1:0] inv_way;
  logic [WAY_BITS-1:0] min_way;
  logic [LRU_BITS-1:0] min_val;
  logic [LRU_BITS-1:0] cur;

  // Scan ways in index order; strict compares keep the lowest index on ties.
  always_comb begin
    found_inv = 1'b0;
    inv_way   = '0;
    min_way   = '0;
    cur       = '0;
    min_val   = counts[LRU_BITS-1:0];
    max_count = counts[LRU_BITS-1:0];
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      cur = counts[i*LRU_BITS +: LRU_BITS];
      if (!valid_mask[i] && !found_inv) begin
        found_inv = 1'b1;
        inv_way   = WAY_BITS'(i);
      end
      if (cur < min_val) begin
        min_val = cur;
        min_way = WAY_BITS'(i);
      end
      if (cur > max_count) begin
        max_count = cur;
      end
    end
    victim_way = found_inv ? inv_way : min_way;
  end

endmodule

// File: rtl/tlb_lru_tracker.sv
// Per-set LRU recency tracker with registered victim query and a
// one-set-per-cycle flush sweep.
module tlb_lru_tracker
  import tlb_lru_tracker_pkg::*;
#(
  parameter int unsigned NUM_WAYS = NUM_WAYS_DEF,
  parameter int unsigned LRU_BITS = LRU_BITS_DEF,
  parameter int unsigned NUM_SETS = NUM_SETS_DEF,
  localparam int unsigned WAY_BITS = $clog2(NUM_WAYS),
  localparam int unsigned SET_BITS = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                touch_valid,
  input  logic [SET_BITS-1:0] touch_set,
  input  logic [WAY_BITS-1:0] touch_way,
  input  logic                query_valid,
  input  logic [SET_BITS-1:0] query_set,
  input  logic [NUM_WAYS-1:0] valid_mask,
  output logic                victim_valid,
  output logic [WAY_BITS-1:0] victim_way,
  output logic [LRU_BITS-1:0] victim_max,
  input  logic                flush_req,
  output logic                busy
);

  tracker_state_t state;
  logic [SET_BITS-1:0] flush_idx;
  logic [LRU_BITS-1:0] cnt [NUM_SETS][NUM_WAYS];

  logic [NUM_WAYS*LRU_BITS-1:0] query_counts;
  logic [NUM_WAYS*LRU_BITS-1:0] touch_counts;
  logic [WAY_BITS-1:0]          query_way;
  logic [LRU_BITS-1:0]          query_max;
  logic [LRU_BITS-1:0]          touch_max;
  logic [WAY_BITS-1:0]          touch_pick_unused;

  // Flatten the queried and touched sets for the selection logic.
  always_comb begin
    query_counts = '0;
    touch_counts = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      query_counts[w*LRU_BITS +: LRU_BITS] = cnt[query_set][w];
      touch_counts[w*LRU_BITS +: LRU_BITS] = cnt[touch_set][w];
    end
  end

  tlb_lru_pick #(
    .NUM_WAYS (NUM_WAYS),
    .LRU_BITS (LRU_BITS)
  ) u_query_pick (
    .counts     (query_counts),
    .valid_mask (valid_mask),
    .victim_way (query_way),
    .max_count  (query_max)
  );

  tlb_lru_pick #(
    .NUM_WAYS (NUM_WAYS),
    .LRU_BITS (LRU_BITS)
  ) u_touch_pick (
    .counts     (touch_counts),
    .valid_mask ({NUM_WAYS{1'b1}}),
    .victim_way (touch_pick_unused),
    .max_count  (touch_max)
  );

  // Control FSM, counter updates and registered query results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      flush_idx    <= '0;
      busy         <= 1'b0;
      victim_valid <= 1'b0;
      victim_way   <= '0;
      victim_max   <= '0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          cnt[s][w] <= '0;
        end
      end
    end else begin
      case (state)
        ST_IDLE: begin
          // Query samples pre-touch counters, so same-set touch is invisible.
          victim_valid <= query_valid && !flush_req;
          if (query_valid && !flush_req) begin
            victim_way <= query_way;
            victim_max <= query_max;
          end
          if (flush_req) begin
            state     <= ST_FLUSH;
            busy      <= 1'b1;
            flush_idx <= '0;
          end else if (touch_valid) begin
            if (touch_max != '1) begin
              cnt[touch_set][touch_way] <= touch_max + LRU_BITS'(1);
            end else begin
              // Saturated set: halve everyone, touched way lands just above.
              for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                cnt[touch_set][w] <= cnt[touch_set][w] >> 1;
              end
              cnt[touch_set][touch_way] <= (touch_max >> 1) + LRU_BITS'(1);
            end
          end
        end
        ST_FLUSH: begin
          victim_valid <= 1'b0;
          for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            cnt[flush_idx][w] <= '0;
          end
          if (flush_idx == SET_BITS'(NUM_SETS - 1)) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            flush_idx <= '0;
          end else begin
            flush_idx <= flush_idx + SET_BITS'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_lru_tracker.sv
// Self-checking bench for tlb_lru_tracker: directed scenarios plus random
// traffic against a behavioural array model of the recency counters.
module tb_tlb_lru_tracker;

  localparam int NW   = 4;
  localparam int LB   = 4;
  localparam int NS   = 16;
  localparam int CMAX = (1 << LB) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       touch_valid;
  logic [3:0] touch_set;
  logic [1:0] touch_way;
  logic       query_valid;
  logic [3:0] query_set;
  logic [3:0] valid_mask;
  logic       victim_valid;
  logic [1:0] victim_way;
  logic [3:0] victim_max;
  logic       flush_req;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m [NS][NW];
  int flush_left = 0;
  logic exp_vv = 1'b0;
  logic exp_busy = 1'b0;
  logic exp_wm = 1'b0;
  int exp_way = 0;
  int exp_max = 0;

  always #5 clk = ~clk;

  tlb_lru_tracker #(
    .NUM_WAYS (NW),
    .LRU_BITS (LB),
    .NUM_SETS (NS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .touch_valid  (touch_valid),
    .touch_set    (touch_set),
    .touch_way    (touch_way),
    .query_valid  (query_valid),
    .query_set    (query_set),
    .valid_mask   (valid_mask),
    .victim_valid (victim_valid),
    .victim_way   (victim_way),
    .victim_max   (victim_max),
    .flush_req    (flush_req),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int set_max(input int s);
    int mx = 0;
    for (int i = 0; i < NW; i++) if (m[s][i] > mx) mx = m[s][i];
    return mx;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) m[s][w] = 0;
  endtask

  task automatic model_victim(input int s, input logic [3:0] mask, output int w, output int mx);
    mx = set_max(s);
    w = -1;
    for (int i = 0; i < NW; i++) begin
      if (w < 0 && !mask[i]) w = i;
    end
    if (w < 0) begin
      w = 0;
      for (int i = 1; i < NW; i++) if (m[s][i] < m[s][w]) w = i;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int w, mx;
    if (rst) begin
      clear_model();
      flush_left = 0;
      exp_busy = 1'b0;
      exp_vv = 1'b0;
      exp_wm = 1'b1;
      exp_way = 0;
      exp_max = 0;
    end else if (flush_left > 0) begin
      flush_left--;
      exp_busy = (flush_left > 0);
      exp_vv = 1'b0;
      exp_wm = 1'b0;
    end else begin
      exp_vv = 1'b0;
      exp_wm = 1'b0;
      if (query_valid && !flush_req) begin
        model_victim(int'(query_set), valid_mask, w, mx);
        exp_vv = 1'b1;
        exp_wm = 1'b1;
        exp_way = w;
        exp_max = mx;
      end
      if (flush_req) begin
        clear_model();
        flush_left = NS;
        exp_busy = 1'b1;
      end else if (touch_valid) begin
        mx = set_max(int'(touch_set));
        if (mx < CMAX) begin
          m[touch_set][touch_way] = mx + 1;
        end else begin
          for (int i = 0; i < NW; i++) m[touch_set][i] = m[touch_set][i] / 2;
          m[touch_set][touch_way] = mx / 2 + 1;
        end
      end
    end
  endtask

  // Compare DUT outputs against the model one step after every edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("busy", busy, exp_busy);
      check("victim_valid", victim_valid, exp_vv);
      if (exp_wm) begin
        check("victim_way", victim_way, exp_way);
        check("victim_max", victim_max, exp_max);
      end
    end
  end

  task automatic set_idle();
    rst = 1'b0;
    touch_valid = 1'b0;
    touch_set = '0;
    touch_way = '0;
    query_valid = 1'b0;
    query_set = '0;
    valid_mask = '1;
    flush_req = 1'b0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #2;
    set_idle();
  endtask

  task automatic do_touch(input int s, input int w);
    touch_valid = 1'b1;
    touch_set = 4'(s);
    touch_way = 2'(w);
    cycle();
  endtask

  task automatic do_query(input int s, input logic [3:0] mask);
    query_valid = 1'b1;
    query_set = 4'(s);
    valid_mask = mask;
    cycle();
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    chk_en = 1'b1;
    cycle();
    check("reset_busy", busy, 0);
    check("reset_vv", victim_valid, 0);

    // Fresh query of set 0.
    do_query(0, 4'b1111);
    check("q0_vv", victim_valid, 1);
    check("q0_way", victim_way, 0);
    check("q0_max", victim_max, 0);

    // Set 3: touches to ways 2,0,1 give counts [2,3,1,0].
    do_touch(3, 2);
    do_touch(3, 0);
    do_touch(3, 1);
    check("model_s3", {m[3][0][7:0], m[3][1][7:0], m[3][2][7:0], m[3][3][7:0]}, 32'h02030100);
    do_query(3, 4'b1111);
    check("q3_way", victim_way, 3);
    check("q3_max", victim_max, 3);
    do_query(3, 4'b1011);
    check("q3_inv_way", victim_way, 2);

    // Load set 5 to [15,4,9,2], then a saturating touch of way 3.
    do_touch(5, 3); do_touch(5, 3);
    do_touch(5, 1); do_touch(5, 1);
    for (int i = 0; i < 5; i++) do_touch(5, 2);
    for (int i = 0; i < 6; i++) do_touch(5, 0);
    check("model_s5_load", {m[5][0][7:0], m[5][1][7:0], m[5][2][7:0], m[5][3][7:0]}, 32'h0F040902);
    do_touch(5, 3);
    check("model_s5_shift", {m[5][0][7:0], m[5][1][7:0], m[5][2][7:0], m[5][3][7:0]}, 32'h07020408);
    do_query(5, 4'b1111);
    check("q5_way", victim_way, 1);
    check("q5_max", victim_max, 8);

    // Same-cycle touch and query see pre-touch counters.
    touch_valid = 1'b1; touch_set = 4'd5; touch_way = 2'd0;
    do_query(5, 4'b1111);
    check("q5_same_way", victim_way, 1);
    check("q5_same_max", victim_max, 8);
    do_query(5, 4'b1111);
    check("q5_after_max", victim_max, 9);

    // Flush sweep: busy for exactly NS cycles, inputs ignored meanwhile.
    flush_req = 1'b1;
    cycle();
    check("flush_busy_start", busy, 1);
    for (int k = 0; k < NS; k++) begin
      touch_valid = 1'b1;
      touch_set = 4'($urandom_range(0, NS - 1));
      touch_way = 2'($urandom_range(0, NW - 1));
      query_valid = 1'b1;
      query_set = 4'($urandom_range(0, NS - 1));
      cycle();
      check("flush_busy", busy, (k < NS - 1) ? 1 : 0);
      check("flush_vv", victim_valid, 0);
    end
    for (int s = 0; s < NS; s++) begin
      do_query(s, 4'b1111);
      check("post_flush_way", victim_way, 0);
      check("post_flush_max", victim_max, 0);
    end

    // Reset during flush cycle 5 aborts the sweep and clears everything.
    do_touch(10, 1);
    do_touch(10, 1);
    flush_req = 1'b1;
    cycle();
    for (int k = 0; k < 4; k++) cycle();
    check("mid_flush_busy", busy, 1);
    rst = 1'b1;
    cycle();
    check("rst_abort_busy", busy, 0);
    do_touch(0, 2);
    check("rst_after_busy", busy, 0);
    do_query(0, 4'b1111);
    check("rst_touch_way", victim_way, 0);
    check("rst_touch_max", victim_max, 1);
    do_query(10, 4'b1111);
    check("rst_s10_max", victim_max, 0);

    // Random traffic concentrated on a few sets so saturation is exercised.
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      flush_req = ($urandom_range(0, 149) == 0);
      touch_valid = ($urandom_range(0, 9) < 6);
      touch_set = 4'($urandom_range(0, 3));
      touch_way = 2'($urandom_range(0, NW - 1));
      query_valid = !flush_req && ($urandom_range(0, 1) == 1);
      query_set = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, NS - 1))
                                              : 4'($urandom_range(0, 3));
      valid_mask = ($urandom_range(0, 1) == 1) ? 4'b1111 : 4'($urandom_range(0, 15));
      cycle();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
